any1_memseq: RTL and testbench
==============================

# any1_memseq

Memory access sequencer between the ANY-1 load/store unit and the 256-bit system bus. Takes one load/store/CALL/RTS request with its unshifted byte-lane select and byte address, aligns lanes and data to the 32-byte bus line, and runs one or two bus cycles. A request that crosses a line boundary is split into two. Read data is merged, realigned to byte 0 and returned with a one-cycle done pulse.

## Interface
- `TIMEOUT`, default 255: cycles a bus access may wait for ack/err before abort (1..1023).
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_i`  in  1  request strobe; sampled only when `busy_o`=0.
- `we_i`  in  1  1=store, 0=load.
- `adr_i`  in  32  byte address of access.
- `sel_i`  in  32  unshifted byte-lane select (lane 0 = lowest byte of operand).
- `wdat_i`  in  256  store operand, byte 0 = lowest byte.
- `busy_o`  out  1  high in every state except IDLE.
- `done_o`  out  1  one-cycle completion pulse.
- `err_o`  out  1  valid with `done_o`: bus error or timeout.
- `rdat_o`  out  256  load result aligned to byte 0; held until next `done_o`.
- `cyc_o`, `stb_o`, `we_o`  out  1 each  bus cycle, strobe, write enable.
- `adr_o`  out  32  line address; `adr_o[4:0]`=0 always.
- `sel_o`  out  32  bus byte lanes.
- `dat_o`  out  256  bus write data.
- `ack_i`, `err_i`  in  1 each  bus acknowledge, bus error.
- `dat_i`  in  256  bus read data.

## Operation
- On accept, register: `ofs`=`adr_i[4:0]`; 64-bit `msel`=`{32'b0,sel_i}<<ofs`; 512-bit `mdat`=`{256'b0,wdat_i}<<(8*ofs)`; line `L`=`{adr_i[31:5],5'b0}`; `split`=(`msel[63:32]`≠0).
- Access 1: `adr_o`=L, `sel_o`=`msel[31:0]`, `dat_o`=`mdat[255:0]`. Access 2: `adr_o`=L+32 (32-bit wrap, 0xFFFFFFE0→0), `sel_o`=`msel[63:32]`, `dat_o`=`mdat[511:256]`.
- Load data: access 1 ack captures `dat_i` into `rbuf[255:0]`, access 2 into `rbuf[511:256]`; `rdat_o`=`(rbuf>>(8*ofs))[255:0]` on completion. Unselected bytes are don't-care. `rdat_o` is not updated for stores or errors.
- States: IDLE, ACC1, GAP, ACC2, DONE.
- IDLE: `req_i` & `sel_i`≠0 → ACC1. `req_i` & `sel_i`=0 → DONE with no bus cycle, `err_o`=0.
- ACC1: `cyc_o`=`stb_o`=1, `we_o`=stored we. If `err_i`, or timer reaches `TIMEOUT`: → DONE, err=1. Else if `ack_i`: → GAP when split, else → DONE with err=0. `err_i` has priority over `ack_i` in the same cycle.
- GAP: `cyc_o`=1, `stb_o`=0 for exactly one cycle → ACC2. The bus is not released between halves.
- ACC2: same exit rules as ACC1; exit always → DONE.
- DONE: `cyc_o`=`stb_o`=0, `done_o`=1, `err_o`=latched err, `busy_o`=1 → IDLE.
- Timer: cleared on entry to ACC1/ACC2, increments each cycle without ack/err. Timeout applies per access. After err/timeout no further access is issued.
- `req_i` while busy is ignored; nothing is queued.
- Reset values: state IDLE; `cyc_o`,`stb_o`,`we_o`,`done_o`,`err_o`,`busy_o`=0; `sel_o`=0; `adr_o`=0; `dat_o`=0; `rdat_o`=0.

## Timing
- Accept at edge 0 → `cyc_o`/`stb_o` high in cycle 1. All bus outputs are registered.
- Non-split access with ack in cycle 1: `done_o` in cycle 2. Each wait state adds one cycle.
- Split access, zero wait: ACC1 cycle 1, GAP cycle 2, ACC2 cycle 3, `done_o` cycle 4.
- Zero-sel request: `done_o` in cycle 1.
- Earliest next accept: the cycle after `done_o` (IDLE).
- Timeout: `done_o`+`err_o` in cycle `TIMEOUT`+2 after an access starts with no response.
- `rst_i` mid-operation: next cycle in IDLE with `cyc_o`/`stb_o` low. No `done_o` is produced and the request is lost.
- `ack_i`/`err_i` outside ACC1/ACC2 are ignored.

## Test plan
- Load, `adr_i`=0x1000, `sel_i`=0xFF, ack cycle 1:
  - required: `adr_o`=0x1000, `sel_o`=0x000000FF, `done_o` cycle 2, `rdat_o[63:0]`=`dat_i[63:0]`.
- Store, `adr_i`=0x101C, `sel_i`=0xFF, `wdat_i[63:0]`=0x1122334455667788:
  - access 1: `adr_o`=0x1000, `sel_o`=0xF0000000, `dat_o[255:224]`=0x55667788.
  - GAP cycle follows with `cyc_o`=1, `stb_o`=0.
  - access 2: `adr_o`=0x1020, `sel_o`=0x0000000F, `dat_o[31:0]`=0x11223344.
  - `done_o` cycle 4.
- Split load at `adr_i`=0x101E, `sel_i`=0xF, line 0x1000 byte 30..31=0xBBAA, line 0x1020 byte 0..1=0xDDCC:
  - required: `rdat_o[31:0]`=0xDDCCBBAA.
- No ack, `TIMEOUT`=4:
  - required: `done_o`=1, `err_o`=1 in cycle 6; `cyc_o` low; no second access on a split request.
- `err_i` with `ack_i` in ACC1 of a split request:
  - required: `err_o`=1, no ACC2, `rdat_o` unchanged.
- Request with `sel_i`=0:
  - required: `done_o` cycle 1, no `cyc_o`.
- `rst_i` in GAP:
  - required: next cycle idle, no `done_o`.
- `req_i` during busy:
  - required: ignored.

Source files
------------

// File: rtl/any1_memseq.sv
// ANY-1 memory access sequencer: aligns a load/store request onto the
// 256-bit system bus. A request that straddles a 32-byte line runs as two
// back-to-back bus accesses, and the bus is held between them. Load data is
// merged and shifted back down to byte 0.
module any1_memseq #(
    parameter int TIMEOUT = 255
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_i,
    input  logic         we_i,
    input  logic [31:0]  adr_i,
    input  logic [31:0]  sel_i,
    input  logic [255:0] wdat_i,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o,
    output logic [255:0] rdat_o,
    output logic         cyc_o,
    output logic         stb_o,
    output logic         we_o,
    output logic [31:0]  adr_o,
    output logic [31:0]  sel_o,
    output logic [255:0] dat_o,
    input  logic         ack_i,
    input  logic         err_i,
    input  logic [255:0] dat_i
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] ACC1 = 3'd1;
    localparam logic [2:0] GAP  = 3'd2;
    localparam logic [2:0] ACC2 = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam logic [9:0] TMO = 10'(TIMEOUT);

    logic [2:0]   state_reg;
    logic [4:0]   ofs_reg;
    logic [31:0]  line_reg;
    logic [31:0]  msel_hi_reg;   // lanes for the second line, zero when not split
    logic [255:0] mdat_hi_reg;   // store data for the second line
    logic         we_reg;
    logic [9:0]   timer_reg;
    logic [255:0] rbuf_lo_reg;   // first-line read data, kept until the second half arrives

    logic [63:0]  msel_acc;
    logic [511:0] mdat_acc;
    logic [511:0] rbuf_next;
    logic [255:0] rdat_next;
    logic         split;
    logic         timeout_hit;

    // Shift the incoming lane select and store data to the request's line offset
    always_comb begin
        msel_acc = {32'b0, sel_i} << adr_i[4:0];
        mdat_acc = {256'b0, wdat_i} << {adr_i[4:0], 3'b000};
    end

    // Merge the acknowledged read line with any earlier half and realign to byte 0
    always_comb begin
        if (state_reg == ACC2) begin
            rbuf_next = {dat_i, rbuf_lo_reg};
        end else begin
            rbuf_next = {256'b0, dat_i};
        end
        rdat_next = 256'(rbuf_next >> {ofs_reg, 3'b000});
    end

    assign split       = (msel_hi_reg != 32'b0);
    assign timeout_hit = (timer_reg == TMO);

    // Sequencer state, registered bus outputs and completion handshake
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= IDLE;
            ofs_reg     <= '0;
            line_reg    <= '0;
            msel_hi_reg <= '0;
            mdat_hi_reg <= '0;
            we_reg      <= 1'b0;
            timer_reg   <= '0;
            rbuf_lo_reg <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            rdat_o      <= '0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            sel_o       <= '0;
            dat_o       <= '0;
        end else begin
            done_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_i) begin
                        ofs_reg     <= adr_i[4:0];
                        line_reg    <= {adr_i[31:5], 5'b0};
                        msel_hi_reg <= msel_acc[63:32];
                        mdat_hi_reg <= mdat_acc[511:256];
                        we_reg      <= we_i;
                        busy_o      <= 1'b1;
                        if (sel_i != 32'b0) begin
                            state_reg <= ACC1;
                            cyc_o     <= 1'b1;
                            stb_o     <= 1'b1;
                            we_o      <= we_i;
                            adr_o     <= {adr_i[31:5], 5'b0};
                            sel_o     <= msel_acc[31:0];
                            dat_o     <= mdat_acc[255:0];
                            timer_reg <= '0;
                        end else begin
                            // Nothing selected: complete without touching the bus
                            state_reg <= DONE;
                            done_o    <= 1'b1;
                            err_o     <= 1'b0;
                        end
                    end
                end
                ACC1, ACC2: begin
                    if (err_i || timeout_hit) begin
                        // Abort: no further access is issued, read data is dropped
                        state_reg <= DONE;
                        cyc_o     <= 1'b0;
                        stb_o     <= 1'b0;
                        we_o      <= 1'b0;
                        done_o    <= 1'b1;
                        err_o     <= 1'b1;
                    end else if (ack_i) begin
                        if (state_reg == ACC1) begin
                            rbuf_lo_reg <= dat_i;
                        end
                        if (state_reg == ACC1 && split) begin
                            state_reg <= GAP;
                            stb_o     <= 1'b0;
                        end else begin
                            state_reg <= DONE;
                            cyc_o     <= 1'b0;
                            stb_o     <= 1'b0;
                            we_o      <= 1'b0;
                            done_o    <= 1'b1;
                            err_o     <= 1'b0;
                            if (!we_reg) begin
                                rdat_o <= rdat_next;
                            end
                        end
                    end else begin
                        timer_reg <= timer_reg + 10'd1;
                    end
                end
                GAP: begin
                    // Keep cyc asserted so the bus stays ours for the second half
                    state_reg <= ACC2;
                    stb_o     <= 1'b1;
                    adr_o     <= line_reg + 32'd32;
                    sel_o     <= msel_hi_reg;
                    dat_o     <= mdat_hi_reg;
                    timer_reg <= '0;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_o    <= 1'b0;
                    err_o     <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_any1_memseq.sv
// Self-checking bench for any1_memseq: directed cases followed by random
// requests, checked against a byte-address model of where each operand byte
// must land on the bus and where each read byte must come from.
module tb_any1_memseq;

    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         req_i;
    logic         we_i;
    logic [31:0]  adr_i;
    logic [31:0]  sel_i;
    logic [255:0] wdat_i;
    logic         busy_o;
    logic         done_o;
    logic         err_o;
    logic [255:0] rdat_o;
    logic         cyc_o;
    logic         stb_o;
    logic         we_o;
    logic [31:0]  adr_o;
    logic [31:0]  sel_o;
    logic [255:0] dat_o;
    logic         ack_i;
    logic         err_i;
    logic [255:0] dat_i;

    int n_assert = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    logic [255:0] line_data [2];
    logic [255:0] model_rdat;
    logic [255:0] model_mask;

    always #5 clk = ~clk;

    any1_memseq #(.TIMEOUT(TMO)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .we_i   (we_i),
        .adr_i  (adr_i),
        .sel_i  (sel_i),
        .wdat_i (wdat_i),
        .busy_o (busy_o),
        .done_o (done_o),
        .err_o  (err_o),
        .rdat_o (rdat_o),
        .cyc_o  (cyc_o),
        .stb_o  (stb_o),
        .we_o   (we_o),
        .adr_o  (adr_o),
        .sel_o  (sel_o),
        .dat_o  (dat_o),
        .ack_i  (ack_i),
        .err_i  (err_i),
        .dat_i  (dat_i)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // fault: 0 none, 1 err+ack on access 1, 2 timeout on access 1,
    //        3 err on access 2, 4 timeout on access 2
    task automatic run_txn(input logic we, input logic [31:0] adr, input logic [31:0] sel,
                           input logic [255:0] wdat, input int w1, input int w2, input int fault);
        logic [31:0]  esel  [2];
        logic [255:0] edat  [2];
        logic [255:0] dmask [2];
        logic [31:0]  eadr  [2];
        logic [255:0] erd;
        logic [255:0] rmask;
        logic [31:0]  a;
        int           hh;
        int           l;
        int           nacc;
        int           waits;
        int           cyc;
        bit           to;
        bit           fail_here;
        bit           exp_err;

        // Model: route each selected operand byte by its absolute byte address
        for (int k = 0; k < 2; k++) begin
            esel[k]  = '0;
            edat[k]  = '0;
            dmask[k] = '0;
        end
        erd     = '0;
        rmask   = '0;
        eadr[0] = adr & 32'hFFFF_FFE0;
        eadr[1] = eadr[0] + 32'd32;
        for (int i = 0; i < 32; i++) begin
            if (sel[i]) begin
                a  = adr + 32'(i);
                hh = ((a & 32'hFFFF_FFE0) == eadr[0]) ? 0 : 1;
                l  = int'(a[4:0]);
                esel[hh][l]          = 1'b1;
                edat[hh][8*l +: 8]   = wdat[8*i +: 8];
                dmask[hh][8*l +: 8]  = 8'hFF;
                erd[8*i +: 8]        = line_data[hh][8*l +: 8];
                rmask[8*i +: 8]      = 8'hFF;
            end
        end
        nacc    = (sel == 32'b0) ? 0 : ((esel[1] != 32'b0) ? 2 : 1);
        exp_err = (nacc > 0 && (fault == 1 || fault == 2)) ||
                  (nacc == 2 && (fault == 3 || fault == 4));

        req_i  = 1'b1;
        we_i   = we;
        adr_i  = adr;
        sel_i  = sel;
        wdat_i = wdat;
        step();
        cyc = 1;

        for (int h = 0; h < nacc; h++) begin
            to        = (fault == 2 && h == 0) || (fault == 4 && h == 1);
            fail_here = ((fault == 1 || fault == 2) && h == 0) || ((fault == 3 || fault == 4) && h == 1);
            waits     = to ? TMO : ((h == 0) ? w1 : w2);
            for (int k = 0; k <= waits; k++) begin
                chk("acc_cyc",  cyc_o,  1'b1);
                chk("acc_stb",  stb_o,  1'b1);
                chk("acc_we",   we_o,   we);
                chk("acc_adr",  adr_o,  eadr[h]);
                chk("acc_sel",  sel_o,  esel[h]);
                chk("acc_busy", busy_o, 1'b1);
                chk("acc_done", done_o, 1'b0);
                if (we) chk("acc_dat", dat_o & dmask[h], edat[h]);
                // Requests while busy must be ignored
                req_i  = 1'($urandom_range(0, 1));
                we_i   = 1'($urandom_range(0, 1));
                adr_i  = $urandom;
                sel_i  = $urandom;
                ack_i  = 1'b0;
                err_i  = 1'b0;
                dat_i  = rand256();
                if (k == waits && !to) begin
                    dat_i = line_data[h];
                    if (fail_here) begin
                        err_i = 1'b1;
                        ack_i = (fault == 1);
                    end else begin
                        ack_i = 1'b1;
                    end
                end
                step();
                cyc++;
            end
            ack_i = 1'b0;
            err_i = 1'b0;
            if (fail_here) break;
            if (h == 0 && nacc == 2) begin
                chk("gap_cyc",  cyc_o,  1'b1);
                chk("gap_stb",  stb_o,  1'b0);
                chk("gap_done", done_o, 1'b0);
                req_i = 1'($urandom_range(0, 1));
                ack_i = 1'($urandom_range(0, 1));
                err_i = 1'($urandom_range(0, 1));
                step();
                ack_i = 1'b0;
                err_i = 1'b0;
                cyc++;
            end
        end

        req_i = 1'b0;
        chk("done_pulse", done_o, 1'b1);
        chk("done_err",   err_o,  exp_err);
        chk("done_cyc",   cyc_o,  1'b0);
        chk("done_stb",   stb_o,  1'b0);
        chk("done_busy",  busy_o, 1'b1);
        if (!we && !exp_err && nacc > 0) begin
            model_rdat = erd;
            model_mask = rmask;
        end
        chk("done_rdat", rdat_o & model_mask, model_rdat & model_mask);
        n_txn++;
        $display("txn %0d: we=%0b adr=%08h sel=%08h accesses=%0d fault=%0d err=%0b done in cycle %0d",
                 n_txn, we, adr, sel, nacc, fault, exp_err, cyc);
        step();
        chk("idle_done", done_o, 1'b0);
        chk("idle_busy", busy_o, 1'b0);
        chk("idle_cyc",  cyc_o,  1'b0);
    endtask

    initial begin
        logic [31:0]  ra;
        logic [31:0]  rs;
        logic [255:0] st;
        int           sz;
        int           fr;
        int           flt;

        rst_i  = 1'b1;
        req_i  = 1'b0;
        we_i   = 1'b0;
        adr_i  = '0;
        sel_i  = '0;
        wdat_i = '0;
        ack_i  = 1'b0;
        err_i  = 1'b0;
        dat_i  = '0;
        model_rdat = '0;
        model_mask = '1;
        step();
        step();
        chk("rst_cyc",  cyc_o,  1'b0);
        chk("rst_stb",  stb_o,  1'b0);
        chk("rst_we",   we_o,   1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err",  err_o,  1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_sel",  sel_o,  32'b0);
        chk("rst_adr",  adr_o,  32'b0);
        chk("rst_dat",  dat_o,  256'b0);
        chk("rst_rdat", rdat_o, 256'b0);
        rst_i = 1'b0;
        step();

        // Aligned 8-byte load, zero wait
        line_data[0] = rand256();
        line_data[1] = rand256();
        run_txn(1'b0, 32'h0000_1000, 32'h0000_00FF, rand256(), 0, 0, 0);
        chk("t1_rdat64", {192'b0, rdat_o[63:0]}, {192'b0, line_data[0][63:0]});

        // Split 8-byte store across 0x1000/0x1020
        st = rand256();
        st[63:0] = 64'h1122_3344_5566_7788;
        run_txn(1'b1, 32'h0000_101C, 32'h0000_00FF, st, 0, 0, 0);

        // Split 4-byte load reassembled from two lines
        line_data[0] = rand256();
        line_data[1] = rand256();
        line_data[0][255:240] = 16'hBBAA;
        line_data[1][15:0]    = 16'hDDCC;
        run_txn(1'b0, 32'h0000_101E, 32'h0000_000F, rand256(), 1, 2, 0);
        chk("t3_rdat32", {224'b0, rdat_o[31:0]}, {224'b0, 32'hDDCC_BBAA});

        // Timeout on first half of a split load: no second access
        run_txn(1'b0, 32'h0000_301C, 32'h0000_00FF, rand256(), 0, 0, 2);

        // err with ack in ACC1 of a split load: rdat keeps the previous result
        line_data[0] = rand256();
        line_data[1] = rand256();
        run_txn(1'b0, 32'h0000_401C, 32'h0000_00FF, rand256(), 0, 0, 1);
        chk("t5_rdat_kept", {224'b0, rdat_o[31:0]}, {224'b0, 32'hDDCC_BBAA});

        // Zero lane select: done in cycle 1 with no bus cycle
        run_txn(1'b0, 32'h0000_5000, 32'h0000_0000, rand256(), 0, 0, 0);

        // Store wrapping from the top line to address 0
        run_txn(1'b1, 32'hFFFF_FFF8, 32'h0000_FFFF, rand256(), 0, 1, 0);

        // Reset during GAP: next cycle idle, no done, request lost
        line_data[0] = rand256();
        req_i = 1'b1;
        we_i  = 1'b0;
        adr_i = 32'h0000_2010;
        sel_i = 32'hFFFF_FFFF;
        step();
        req_i = 1'b0;
        chk("rg_acc1_stb", stb_o, 1'b1);
        ack_i = 1'b1;
        dat_i = line_data[0];
        step();
        ack_i = 1'b0;
        chk("rg_gap_cyc", cyc_o, 1'b1);
        chk("rg_gap_stb", stb_o, 1'b0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("rg_cyc",  cyc_o,  1'b0);
        chk("rg_stb",  stb_o,  1'b0);
        chk("rg_busy", busy_o, 1'b0);
        chk("rg_done", done_o, 1'b0);
        chk("rg_rdat", rdat_o, 256'b0);
        model_rdat = '0;
        model_mask = '1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rg_after_done", done_o, 1'b0);
            chk("rg_after_cyc",  cyc_o,  1'b0);
        end
        n_txn++;
        $display("txn %0d: split load adr=00002010 reset in GAP, no completion", n_txn);

        // Random requests
        for (int t = 0; t < 40; t++) begin
            line_data[0] = rand256();
            line_data[1] = rand256();
            ra = $urandom;
            if ($urandom_range(0, 1) == 1) ra[4:0] = 5'($urandom_range(24, 31));
            sz = $urandom_range(0, 7);
            case (sz)
                0:       rs = $urandom;
                1:       rs = 32'h0000_0001;
                2:       rs = 32'h0000_0003;
                3:       rs = 32'h0000_000F;
                4:       rs = 32'h0000_00FF;
                5:       rs = 32'h0000_FFFF;
                6:       rs = 32'hFFFF_FFFF;
                default: rs = 32'h0000_0000;
            endcase
            fr = $urandom_range(0, 11);
            flt = (fr < 8) ? 0 : fr - 7;
            run_txn(1'($urandom_range(0, 1)), ra, rs, rand256(),
                    $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1), flt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
